reg_file_mp: RTL

//   Parametrised multi-port integer register file for the single-cycle/pipelined RISC-V core.

---
 rtl/reg_file_pkg.sv | 15 +
 rtl/rf_read_port.sv | 41 ++++
 rtl/reg_file_mp.sv | 91 +++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants, index type and helpers for the multi-port integer register file.
package reg_file_pkg;

    localparam int REG_ZERO  = 0;
    localparam int REG_A0    = 10;
    localparam int RF_ADDR_W = 5;

    typedef logic [RF_ADDR_W-1:0] reg_idx_t;

    // Callers zero-extend their index to 32 bits so one helper serves any ADDR_W <= 32.
    function automatic logic idx_is_zero(input logic [31:0] idx);
        return idx == 32'(REG_ZERO);
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: same-cycle write bypass, x0 forcing and busy masking.
module rf_read_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              hold_i,
    input  logic [ADDR_W-1:0] ra_i,
    input  logic [DATA_W-1:0] stored_i,
    input  logic              busy_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] wa0_i,
    input  logic [DATA_W-1:0] wd0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] wa1_i,
    input  logic [DATA_W-1:0] wd1_i,
    output logic [DATA_W-1:0] rd_o,
    output logic              busy_o
);

    always_comb begin
        rd_o   = stored_i;
        busy_o = busy_i;
        if (BYPASS != 0) begin
            // Load port has priority, and a completing load releases the stall immediately.
            if (we1_i && (wa1_i == ra_i)) begin
                rd_o   = wd1_i;
                busy_o = 1'b0;
            end else if (we0_i && (wa0_i == ra_i)) begin
                rd_o = wd0_i;
            end
        end
        if (hold_i || idx_is_zero(32'(ra_i))) begin
            rd_o   = '0;
            busy_o = 1'b0;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file: two write ports (ALU, load), NUM_RD read ports,
// pending-load scoreboard, hardwired x0 and an a0 tap for the display harness.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1,
    parameter int A0_IDX = REG_A0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] RA,
    output logic [NUM_RD*DATA_W-1:0] RD,
    output logic [NUM_RD-1:0]        BUSY,
    input  logic                     WE0,
    input  logic [ADDR_W-1:0]        WA0,
    input  logic [DATA_W-1:0]        WD0,
    input  logic                     WE1,
    input  logic [ADDR_W-1:0]        WA1,
    input  logic [DATA_W-1:0]        WD1,
    input  logic                     BSY_SET,
    input  logic [ADDR_W-1:0]        BSY_ADDR,
    output logic [DATA_W-1:0]        a0
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    // Later assignments win: load over ALU on data, set over clear on the scoreboard.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (WE0 && !idx_is_zero(32'(WA0))) begin
            regs_d[WA0] = WD0;
        end
        if (WE1 && !idx_is_zero(32'(WA1))) begin
            regs_d[WA1] = WD1;
            busy_d[WA1] = 1'b0;
        end
        if (BSY_SET && !idx_is_zero(32'(BSY_ADDR))) begin
            busy_d[BSY_ADDR] = 1'b1;
        end
        regs_d[REG_ZERO] = '0;
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign a0 = regs_q[A0_IDX];

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = RA[i*ADDR_W +: ADDR_W];

        rf_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .BYPASS (BYPASS)
        ) u_port (
            .hold_i   (!rst_n),
            .ra_i     (ra),
            .stored_i (regs_q[ra]),
            .busy_i   (busy_q[ra]),
            .we0_i    (WE0),
            .wa0_i    (WA0),
            .wd0_i    (WD0),
            .we1_i    (WE1),
            .wa1_i    (WA1),
            .wd1_i    (WD1),
            .rd_o     (RD[i*DATA_W +: DATA_W]),
            .busy_o   (BUSY[i])
        );
    end

endmodule
